// File: rtl/segway_math_pipe.sv
// segway_math_pipe: 3-stage PID+steer to left/right motor speed math with soft-start ramp,
// persistence-filtered too_fast and an optional output slew limiter (SEG_SLEW_LIMIT_EN).
module segway_math_pipe #(
  parameter int          PID_W           = 12,
  parameter logic [12:0] MIN_DUTY        = 13'h3C0,
  parameter logic [7:0]  LOW_TORQUE_BAND = 8'h3C,
  parameter logic [5:0]  GAIN_MULT       = 6'h10,
  parameter logic [7:0]  SS_INC          = 8'h01,
  parameter logic [11:0] FAST_THRESH     = 12'd1792,
  parameter int          FAST_CNT        = 4,
  parameter logic [11:0] SLEW_STEP       = 12'h080
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [PID_W-1:0] PID_cntrl,
  input  logic [11:0]      steer_pot,
  input  logic             en_steer,
  input  logic             pwr_up,
  output logic             vld_out,
  output logic [PID_W-1:0] lft_spd,
  output logic [PID_W-1:0] rght_spd,
  output logic             too_fast,
  output logic [7:0]       ss_tmr
);
  localparam int TW     = PID_W + 1;
  localparam int STAGES = 3;
  localparam logic signed [TW-1:0]    MIN_DUTY_S = TW'(MIN_DUTY);
  localparam logic signed [TW-1:0]    BAND_S     = TW'(LOW_TORQUE_BAND);
  localparam logic signed [TW-1:0]    GAIN_S     = TW'(GAIN_MULT);
  localparam logic signed [PID_W-1:0] FAST_S     = PID_W'(FAST_THRESH);
  localparam logic [3:0]              FAST_CNT_V = 4'(FAST_CNT);

  typedef struct packed {
    logic [TW-1:0] pid_ss;
    logic [TW-1:0] steer;
    logic          en_steer;
  } s1_t;

  typedef struct packed {
    logic [TW-1:0] lft;
    logic [TW-1:0] rght;
  } s2_t;

  function automatic logic [TW-1:0] shape(input logic signed [TW-1:0] t);
    if (t > BAND_S || t < -BAND_S) shape = t[TW-1] ? t - MIN_DUTY_S : t + MIN_DUTY_S;
    else                           shape = t * GAIN_S;
  endfunction

  // Top two bits disagree -> value does not fit in PID_W bits.
  function automatic logic [PID_W-1:0] sat(input logic [TW-1:0] t);
    if (t[TW-1] != t[TW-2]) sat = {t[TW-1], {(PID_W-1){~t[TW-1]}}};
    else                    sat = t[PID_W-1:0];
  endfunction

`ifdef SEG_SLEW_LIMIT_EN
  localparam logic signed [TW-1:0] STEP_S = TW'(SLEW_STEP);

  function automatic logic [PID_W-1:0] slew(input logic [PID_W-1:0] cur,
                                            input logic [PID_W-1:0] tgt);
    logic signed [TW-1:0] diff;
    diff = TW'($signed(tgt)) - TW'($signed(cur));
    if (diff > STEP_S)       slew = cur + STEP_S[PID_W-1:0];
    else if (diff < -STEP_S) slew = cur - STEP_S[PID_W-1:0];
    else                     slew = tgt;
  endfunction
`endif

  logic [STAGES:1]        vld_pipe_q, vld_pipe_d;
  logic [STAGES:0]        vld_pipe;
  logic [2:1]             pwr_pipe_q, pwr_pipe_d;
  logic [2:0]             pwr_pipe;
  logic [7:0]             ss_tmr_q, ss_tmr_d;
  logic [8:0]             ss_sum;
  s1_t                    s1_q, s1_d;
  s2_t                    s2_q, s2_d;
  logic [PID_W-1:0]       lft_q, lft_d, rght_q, rght_d;
  logic [3:0]             fast_cnt_q, fast_cnt_d;
  logic                   too_fast_q, too_fast_d;

  logic signed [PID_W+8:0] prod;
  logic [11:0]             clip;
  logic signed [12:0]      cent, steer13;
  logic [TW-1:0]           steer_eff;
  logic signed [TW-1:0]    t_l, t_r;
  logic [PID_W-1:0]        tgt_l, tgt_r;
  logic                    over;

  assign vld_pipe = {vld_pipe_q, vld_in};
  assign pwr_pipe = {pwr_pipe_q, pwr_up};

  always_comb begin
    vld_pipe_d = vld_pipe[STAGES-1:0];
    pwr_pipe_d = pwr_pipe[1:0];

    // Soft-start: the sample uses the pre-increment value.
    ss_sum   = {1'b0, ss_tmr_q} + {1'b0, SS_INC};
    ss_tmr_d = ss_tmr_q;
    if (!pwr_up)     ss_tmr_d = '0;
    else if (vld_in) ss_tmr_d = ss_sum[8] ? 8'hFF : ss_sum[7:0];

    // Stage 1: scale PID by ss_tmr/256, centre and scale the clipped pot.
    prod  = (PID_W+9)'($signed(PID_cntrl)) * (PID_W+9)'($signed({1'b0, ss_tmr_q}));
    clip  = (steer_pot < 12'h200) ? 12'h200 : (steer_pot > 12'hE00) ? 12'hE00 : steer_pot;
    cent  = $signed({1'b0, clip}) - 13'sh7FF;
    steer13 = (cent >>> 4) * 13'sd3;
    s1_d.pid_ss   = prod[PID_W+8:8];
    s1_d.steer    = TW'(steer13);
    s1_d.en_steer = en_steer;

    // Stage 2: per-side torque and dead-zone / low-band shaping.
    steer_eff = s1_q.en_steer ? s1_q.steer : '0;
    t_l       = s1_q.pid_ss + steer_eff;
    t_r       = s1_q.pid_ss - steer_eff;
    s2_d.lft  = pwr_pipe[1] ? shape(t_l) : '0;
    s2_d.rght = pwr_pipe[1] ? shape(t_r) : '0;

    // Stage 3: saturate, filter overspeed, update outputs on valid only.
    tgt_l = sat(s2_q.lft);
    tgt_r = sat(s2_q.rght);
    over  = ($signed(tgt_l) > FAST_S) || ($signed(tgt_r) > FAST_S);
    fast_cnt_d = fast_cnt_q;
    too_fast_d = too_fast_q;
    lft_d      = lft_q;
    rght_d     = rght_q;
    if (vld_pipe[2]) begin
      fast_cnt_d = over ? ((fast_cnt_q == 4'hF) ? 4'hF : fast_cnt_q + 4'd1) : 4'd0;
      too_fast_d = (fast_cnt_d >= FAST_CNT_V);
`ifdef SEG_SLEW_LIMIT_EN
      lft_d  = pwr_pipe[2] ? slew(lft_q, tgt_l) : '0;
      rght_d = pwr_pipe[2] ? slew(rght_q, tgt_r) : '0;
`else
      lft_d  = pwr_pipe[2] ? tgt_l : '0;
      rght_d = pwr_pipe[2] ? tgt_r : '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      pwr_pipe_q <= '0;
      ss_tmr_q   <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      lft_q      <= '0;
      rght_q     <= '0;
      fast_cnt_q <= '0;
      too_fast_q <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      pwr_pipe_q <= pwr_pipe_d;
      ss_tmr_q   <= ss_tmr_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lft_q      <= lft_d;
      rght_q     <= rght_d;
      fast_cnt_q <= fast_cnt_d;
      too_fast_q <= too_fast_d;
    end
  end

  assign vld_out  = vld_pipe[STAGES];
  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign too_fast = too_fast_q;
  assign ss_tmr   = ss_tmr_q;

endmodule

// File: tb/tb_segway_math_pipe.sv
// Directed bench for segway_math_pipe with hand-computed expected speeds and flags.
module tb_segway_math_pipe;
  logic        clk = 1'b0;
  logic        rst, vld_in, en_steer, pwr_up;
  logic [11:0] PID_cntrl, steer_pot;
  logic        vld_out, too_fast;
  logic [11:0] lft_spd, rght_spd;
  logic [7:0]  ss_tmr;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  segway_math_pipe dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .PID_cntrl(PID_cntrl), .steer_pot(steer_pot),
    .en_steer(en_steer), .pwr_up(pwr_up), .vld_out(vld_out), .lft_spd(lft_spd),
    .rght_spd(rght_spd), .too_fast(too_fast), .ss_tmr(ss_tmr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated sample; returns when its output is visible.
  task automatic sample(input logic [11:0] pid, input logic [11:0] pot,
                        input logic en, input logic pw);
    PID_cntrl = pid; steer_pot = pot; en_steer = en; pwr_up = pw; vld_in = 1'b1;
    step();
    vld_in = 1'b0;
    step();
    step();
    chk("vld_out", vld_out, 1'b1);
  endtask

  initial begin
    rst = 1'b1; vld_in = 1'b0; PID_cntrl = '0; steer_pot = 12'h7FF; en_steer = 1'b0; pwr_up = 1'b0;
    repeat (3) step();
    chk("rst vld_out", vld_out, 1'b0);
    chk("rst lft", lft_spd, 12'h000);
    chk("rst rght", rght_spd, 12'h000);
    chk("rst too_fast", too_fast, 1'b0);
    chk("rst ss_tmr", ss_tmr, 8'h00);

    // Soft-start ramp with zero command.
    rst = 1'b0; pwr_up = 1'b1; vld_in = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
        chk("ramp ss_tmr", ss_tmr, (k > 255) ? 255 : k);
    end
    vld_in = 1'b0;
    repeat (4) step();
    chk("idle vld_out", vld_out, 1'b0);
    chk("ramp lft", lft_spd, 12'h000);

`ifdef SEG_SLEW_LIMIT_EN
    for (int k = 1; k <= 10; k++) begin
      logic [11:0] el;
      el = (k < 10) ? 12'(k * 12'h080) : 12'h4E0;
      sample(12'h000, 12'hFFF, 1'b1, 1'b1);
      chk("slew lft", lft_spd, el);
      chk("slew rght", rght_spd, 12'(13'h1000 - {1'b0, el}));
    end
    sample(12'h000, 12'hFFF, 1'b1, 1'b0);
    chk("slew pwr off lft", lft_spd, 12'h000);
    chk("slew pwr off rght", rght_spd, 12'h000);
`else
    // Latency and gain mode: 2*255>>8 = 1, *16.
    PID_cntrl = 12'h002; vld_in = 1'b1;
    step();
    vld_in = 1'b0;
    chk("lat c1", vld_out, 1'b0);
    step();
    chk("lat c2", vld_out, 1'b0);
    step();
    chk("lat c3", vld_out, 1'b1);
    chk("gain lft", lft_spd, 12'h010);
    chk("gain rght", rght_spd, 12'h010);
    step();
    chk("lat c4", vld_out, 1'b0);
    chk("hold lft", lft_spd, 12'h010);

    // Band edges: 61->60 (gain), 62->61 (offset), -61->-61 (offset).
    sample(12'd61, 12'h7FF, 1'b0, 1'b1);
    chk("band60 lft", lft_spd, 12'h3C0);
    sample(12'd62, 12'h7FF, 1'b0, 1'b1);
    chk("band61 lft", lft_spd, 12'h3FD);
    sample(12'hFC3, 12'h7FF, 1'b0, 1'b1);
    chk("band-61 rght", rght_spd, 12'hC03);

    // Positive overspeed persistence.
    for (int i = 1; i <= 4; i++) begin
      sample(12'h7FF, 12'h7FF, 1'b0, 1'b1);
      chk("ovr lft", lft_spd, 12'h7FF);
      chk("ovr rght", rght_spd, 12'h7FF);
      chk("ovr too_fast", too_fast, (i == 4) ? 1'b1 : 1'b0);
    end
    sample(12'h000, 12'h7FF, 1'b0, 1'b1);
    chk("clr too_fast", too_fast, 1'b0);
    chk("clr lft", lft_spd, 12'h000);

    // Negative saturation never counts.
    for (int i = 1; i <= 4; i++) begin
      sample(12'h800, 12'h7FF, 1'b0, 1'b1);
      chk("neg lft", lft_spd, 12'h800);
      chk("neg rght", rght_spd, 12'h800);
      chk("neg too_fast", too_fast, 1'b0);
    end

    // Steering.
    sample(12'h000, 12'hFFF, 1'b1, 1'b1);
    chk("steer hi lft", lft_spd, 12'h4E0);
    chk("steer hi rght", rght_spd, 12'hB20);
    sample(12'h000, 12'h000, 1'b1, 1'b1);
    chk("steer lo lft", lft_spd, 12'hB20);
    chk("steer lo rght", rght_spd, 12'h4E0);
    sample(12'h000, 12'h80F, 1'b1, 1'b1);
    chk("steer small lft", lft_spd, 12'h030);
    chk("steer small rght", rght_spd, 12'hFD0);
    sample(12'h000, 12'hFFF, 1'b0, 1'b1);
    chk("steer off lft", lft_spd, 12'h000);
    chk("steer off rght", rght_spd, 12'h000);

    // Power-down clears ss_tmr and zeroes the next output.
    sample(12'h7FF, 12'h7FF, 1'b0, 1'b1);
    chk("pre-off lft", lft_spd, 12'h7FF);
    PID_cntrl = 12'h7FF; pwr_up = 1'b0; vld_in = 1'b1;
    step();
    chk("off ss_tmr", ss_tmr, 8'h00);
    vld_in = 1'b0;
    step();
    step();
    chk("off vld_out", vld_out, 1'b1);
    chk("off lft", lft_spd, 12'h000);
    chk("off rght", rght_spd, 12'h000);

    // Restart from ss=0, then reset mid-stream.
    pwr_up = 1'b1; vld_in = 1'b1;
    repeat (6) step();
    chk("restart lft", lft_spd, 12'h170);
    chk("restart ss_tmr", ss_tmr, 8'd6);
    chk("restart vld_out", vld_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid rst lft", lft_spd, 12'h000);
    chk("mid rst rght", rght_spd, 12'h000);
    chk("mid rst vld_out", vld_out, 1'b0);
    chk("mid rst ss_tmr", ss_tmr, 8'h00);
    vld_in = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post rst vld_out", vld_out, 1'b0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
